// File: rtl/nn_pkg.sv
// Shared types and helpers for the classifier datapath: argmax FSM states, the default
// score width used by dense_layer/neuron, and the saturating subtract used for margin.
package nn_pkg;

   localparam int NN_DATA_WIDTH = 32;
   localparam int SAT_W = 64;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

   // a - b one bit wider than the operands, clamped to [0, 2^(width-1)-1].
   function automatic logic [SAT_W-1:0] sat_sub(input logic signed [SAT_W-1:0] a,
                                                input logic signed [SAT_W-1:0] b,
                                                input int width);
      logic signed [SAT_W:0] diff;
      logic signed [SAT_W:0] limit;
      diff = (SAT_W+1)'(a) - (SAT_W+1)'(b);
      limit = ((SAT_W+1)'(1) <<< (width - 1)) - (SAT_W+1)'(1);
      if (diff > limit) return SAT_W'(limit);
      if (diff < 0) return '0;
      return SAT_W'(diff);
   endfunction

endpackage

// File: rtl/argmax_layer.sv
// Snapshot NUM_INPUTS signed scores and scan them one per clock for the maximum.
// Define ARGMAX_MARGIN_EN to also track the runner-up and report best-minus-second.
module argmax_layer
   import nn_pkg::*;
#(
   parameter int DATA_WIDTH = NN_DATA_WIDTH,
   parameter int NUM_INPUTS = 10,
   localparam int INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             inputs_ready,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] inputs,
   output logic [INDEX_WIDTH-1:0]           class_index,
   output logic [DATA_WIDTH-1:0]            max_value,
   output logic                             output_ready,
   output logic                             busy
`ifdef ARGMAX_MARGIN_EN
   ,
   output logic [DATA_WIDTH-1:0]            margin
`endif
);

   if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("argmax_layer: NUM_INPUTS must be >= 2");
   end

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

   argmax_state_t                state;
   logic signed [DATA_WIDTH-1:0] snap [NUM_INPUTS];
   logic signed [DATA_WIDTH-1:0] best, candidate, next_best;
   logic [INDEX_WIDTH-1:0]       best_idx, idx, next_idx;
   logic                         last_compare;

`ifdef ARGMAX_MARGIN_EN
   localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   logic signed [DATA_WIDTH-1:0] second, next_second;
`endif

   // Strict greater-than so that ties keep the lower index already held in best.
   always_comb begin
      candidate = snap[idx];
      last_compare = (idx == LAST_IDX);
      next_best = best;
      next_idx = best_idx;
      if (candidate > best) begin
         next_best = candidate;
         next_idx = idx;
      end
`ifdef ARGMAX_MARGIN_EN
      next_second = second;
      if (candidate > best) next_second = best;
      else if (candidate > second) next_second = candidate;
`endif
   end

   // The final SCAN edge registers the result directly, so DONE is the pulse cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         for (int i = 0; i < NUM_INPUTS; i++) snap[i] <= '0;
         best <= '0;
         best_idx <= '0;
         idx <= '0;
         class_index <= '0;
         max_value <= '0;
         output_ready <= 1'b0;
         busy <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
         second <= '0;
         margin <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               output_ready <= 1'b0;
               if (inputs_ready) begin
                  for (int i = 0; i < NUM_INPUTS; i++)
                     snap[i] <= inputs[i*DATA_WIDTH +: DATA_WIDTH];
                  best <= inputs[0 +: DATA_WIDTH];
                  best_idx <= '0;
                  idx <= INDEX_WIDTH'(1);
                  busy <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
                  second <= MIN_SCORE;
`endif
                  state <= SCAN;
               end
            end
            SCAN: begin
               best <= next_best;
               best_idx <= next_idx;
`ifdef ARGMAX_MARGIN_EN
               second <= next_second;
`endif
               if (last_compare) begin
                  class_index <= next_idx;
                  max_value <= next_best;
                  output_ready <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
                  margin <= DATA_WIDTH'(sat_sub(SAT_W'(next_best), SAT_W'(next_second),
                                                DATA_WIDTH));
`endif
                  state <= DONE;
               end else begin
                  idx <= idx + INDEX_WIDTH'(1);
               end
            end
            DONE: begin
               output_ready <= 1'b0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
